chu_slot_master: RTL

- Initiator for the FPro-style MMIO slot bus.
- Converts a host-side valid/ready request into exactly one slot-bus read or write strobe, then returns a response.
- Decodes the slot number into a one-hot chip select, drives reg address, write data and strobes, and captures the selected slot's combinational rd_data.
- Sits between a host (CPU bridge or UART command decoder) and the slot array of peripherals such as timers and GPIO.

---
 rtl/chu_slot_pkg.sv | 24 ++
 rtl/chu_slot_rd_mux.sv | 25 ++
 rtl/chu_slot_master.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/chu_slot_pkg.sv
// Shared types and helpers for the slot-bus master: FSM states, data width,
// one-hot slot decode and flattened read-data selection.
package chu_slot_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  localparam int SLOT_DW   = 32;
  localparam int MAX_AW    = 6;
  localparam int MAX_SLOTS = 1 << MAX_AW;

  function automatic logic [MAX_SLOTS-1:0] slot_dec(input logic [MAX_AW-1:0] idx);
    logic [MAX_SLOTS-1:0] cs;
    cs      = '0;
    cs[idx] = 1'b1;
    return cs;
  endfunction

  // {idx, 5'd0} is idx*SLOT_DW with the exact index width of arr
  function automatic logic [SLOT_DW-1:0] slot_mux(input logic [MAX_SLOTS*SLOT_DW-1:0] arr,
                                                  input logic [MAX_AW-1:0] idx);
    return arr[{idx, 5'd0} +: SLOT_DW];
  endfunction

endpackage

// File: rtl/chu_slot_rd_mux.sv
// Combinational selection of one slot's 32-bit read word from the flattened
// per-slot read-data bus; unpopulated slot positions read as zero.
module chu_slot_rd_mux
  import chu_slot_pkg::*;
#(
  parameter int NUM_SLOTS = 8
) (
  input  logic [SLOT_DW*NUM_SLOTS-1:0] rd_data_flat,
  input  logic [MAX_AW-1:0]            sel,
  output logic [SLOT_DW-1:0]           rd_data
);

  logic [MAX_SLOTS*SLOT_DW-1:0] padded;

  for (genvar gi = 0; gi < MAX_SLOTS; gi++) begin : g_pad
    if (gi < NUM_SLOTS) begin : g_live
      assign padded[gi*SLOT_DW +: SLOT_DW] = rd_data_flat[gi*SLOT_DW +: SLOT_DW];
    end else begin : g_zero
      assign padded[gi*SLOT_DW +: SLOT_DW] = '0;
    end
  end

  assign rd_data = slot_mux(padded, sel);

endmodule

// File: rtl/chu_slot_master.sv
// FPro slot-bus initiator: one host request -> one slot read/write strobe -> one response.
// Optional SLOT_MASTER_WAIT_EN adds RD_WAIT hold cycles before read-data capture.
module chu_slot_master
  import chu_slot_pkg::*;
#(
  parameter int NUM_SLOTS = 8,
  parameter int SLOT_AW   = 6,
  parameter int REG_AW    = 5,
  parameter int RD_WAIT   = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [SLOT_AW+REG_AW-1:0]    req_addr,
  input  logic [SLOT_DW-1:0]           req_wdata,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [SLOT_DW-1:0]           resp_rdata,
  output logic                         resp_err,
  output logic [NUM_SLOTS-1:0]         slot_cs,
  output logic                         slot_read,
  output logic                         slot_write,
  output logic [REG_AW-1:0]            slot_addr,
  output logic [SLOT_DW-1:0]           slot_wr_data,
  input  logic [SLOT_DW*NUM_SLOTS-1:0] slot_rd_data
);

`ifdef SLOT_MASTER_WAIT_EN
  localparam bit WAIT_ON = (RD_WAIT > 0);
  localparam int CW      = (RD_WAIT > 1) ? $clog2(RD_WAIT + 1) : 1;
  logic [CW-1:0] wait_cnt;
`else
  localparam bit WAIT_ON = 1'b0 && (RD_WAIT > 0);
`endif

  state_t               state;
  logic                 write_reg;
  logic [SLOT_AW-1:0]   slot_reg;
  logic [SLOT_AW-1:0]   req_slot;
  logic                 req_in_range;
  logic [MAX_SLOTS-1:0] dec_all;
  logic [SLOT_DW-1:0]   mux_rdata;

  assign req_slot     = req_addr[REG_AW +: SLOT_AW];
  assign req_in_range = ({1'b0, req_slot} < (SLOT_AW+1)'(NUM_SLOTS));
  assign dec_all      = slot_dec(MAX_AW'(req_slot));

  chu_slot_rd_mux #(.NUM_SLOTS(NUM_SLOTS)) u_rd_mux (
    .rd_data_flat (slot_rd_data),
    .sel          (MAX_AW'(slot_reg)),
    .rd_data      (mux_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      write_reg    <= 1'b0;
      slot_reg     <= '0;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      slot_cs      <= '0;
      slot_read    <= 1'b0;
      slot_write   <= 1'b0;
      slot_addr    <= '0;
      slot_wr_data <= '0;
`ifdef SLOT_MASTER_WAIT_EN
      wait_cnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            write_reg <= req_write;
            slot_reg  <= req_slot;
            req_ready <= 1'b0;
            if (req_in_range) begin
              // strobes are registered here so they are live exactly during ACCESS
              slot_cs      <= dec_all[NUM_SLOTS-1:0];
              slot_read    <= !req_write;
              slot_write   <= req_write;
              slot_addr    <= req_addr[REG_AW-1:0];
              slot_wr_data <= req_wdata;
              state        <= ACCESS;
            end else begin
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              resp_valid <= 1'b1;
              state      <= RESP;
            end
          end
        end
        ACCESS: begin
          slot_read  <= 1'b0;
          slot_write <= 1'b0;
          if (WAIT_ON) begin
`ifdef SLOT_MASTER_WAIT_EN
            wait_cnt <= CW'(RD_WAIT);
            state    <= WAIT;
`endif
          end else begin
            resp_rdata <= write_reg ? '0 : mux_rdata;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            slot_cs    <= '0;
            state      <= RESP;
          end
        end
`ifdef SLOT_MASTER_WAIT_EN
        WAIT: begin
          if (wait_cnt == CW'(1)) begin
            resp_rdata <= write_reg ? '0 : mux_rdata;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            slot_cs    <= '0;
            state      <= RESP;
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end
`endif
        RESP: begin
          if (resp_ready) begin
            resp_valid   <= 1'b0;
            resp_err     <= 1'b0;
            resp_rdata   <= '0;
            req_ready    <= 1'b1;
            slot_cs      <= '0;
            slot_addr    <= '0;
            slot_wr_data <= '0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
